// File: rtl/mem_data_port.sv
// mem_data_port: MEM-stage data-memory port. Converts a load/store from the
// pipeline into a single registered request on the memory bus, holds the
// pipeline with stall until the access completes, times out a silent memory,
// and flags illegal accesses (load+store together, or misaligned word address).
//
// Memory handshake: mem_req is the request valid. While mem_req=1, mem_we,
// mem_addr and mem_wdata stay constant. The memory completes the request by
// raising mem_ack for exactly one cycle, which is the ready strobe. mem_rdata
// is meaningful only in that cycle. The transfer happens on the rising edge
// where mem_req=1 and mem_ack=1. mem_ack is ignored whenever no request is
// outstanding.
module mem_data_port #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rd_out,
    output logic        stall,
    output logic        err,
    output logic [1:0]  dbg_state   // 0 = IDLE, 1 = BUSY, 2 = DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic acc;
    logic fault;

    // A legal access is exactly one of load/store to a word-aligned address.
    assign acc   = (MemRead_in ^ MemWrite_in) && (addr_in[1:0] == 2'b00);
    assign fault = (MemRead_in | MemWrite_in) && !acc;

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    req_d   = 1'b1;
                    we_d    = MemWrite_in;
                    addr_d  = addr_in;
                    wdata_d = wd_in;
                    cnt_d   = 8'd0;
                    state_d = S_BUSY;
                end else if (fault) begin
                    err_d = 1'b1;
                end
            end
            S_BUSY: begin
                // An ack arriving on the timeout cycle still completes normally.
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rd_d = mem_rdata;
                    end
                    state_d = S_DONE;
                end else if (cnt_q + 8'd1 == TIMEOUT) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rd_d = 32'd0;
                    end
                    err_d   = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                // One free cycle so the pipeline advances; new requests wait.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall covers the issuing cycle and every waiting cycle, never reset or DONE.
    assign stall = !rst && (((state_q == S_IDLE) && acc) || (state_q == S_BUSY));

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rd_out    = rd_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_data_port.sv
// Bench for mem_data_port: directed scenarios followed by random accesses,
// with expected requests and completions queued at issue time and checked by
// an independent monitor.
module tb_mem_data_port;

    localparam logic [7:0] TP  = 8'd4;
    localparam int         TPI = 4;

    logic        clk;
    logic        rst;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [31:0] addr_in;
    logic [31:0] wd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] rd_out;
    logic        stall;
    logic        err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected requests: {we, addr, wdata}
    logic [64:0] req_q[$];
    // Expected completions: {rd_out, err, stall cycles}
    logic [40:0] res_q[$];

    logic [31:0] rd_model;

    mem_data_port #(.TIMEOUT(TP)) dut (
        .clk         (clk),
        .rst         (rst),
        .MemRead_in  (MemRead_in),
        .MemWrite_in (MemWrite_in),
        .addr_in     (addr_in),
        .wd_in       (wd_in),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rd_out      (rd_out),
        .stall       (stall),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // Issue one access, queue its expected outcome, and play the memory side.
    // d = BUSY cycle in which ack arrives (1 = first); 0 or > TIMEOUT = never.
    task automatic do_acc(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int d, input logic [31:0] rdata,
                          input int gap);
        logic acc;
        logic nack;
        logic e;
        int   st;
        acc  = (rd ^ wr) && (addr[1:0] == 2'b00);
        nack = (d <= 0) || (d > TPI);
        if (!acc) begin
            res_q.push_back({rd_model, 1'b1, 8'd0});
        end else begin
            req_q.push_back({wr, addr, wd});
            if (nack) begin
                if (!wr) rd_model = 32'd0;
                e  = 1'b1;
                st = 1 + TPI;
            end else begin
                if (!wr) rd_model = rdata;
                e  = 1'b0;
                st = 1 + d;
            end
            res_q.push_back({rd_model, e, st[7:0]});
        end
        @(posedge clk); #1;
        MemRead_in  = rd;
        MemWrite_in = wr;
        addr_in     = addr;
        wd_in       = wd;
        mem_ack     = 1'($urandom_range(0, 1));
        mem_rdata   = $urandom();
        @(posedge clk); #1;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        addr_in     = $urandom();
        wd_in       = $urandom();
        mem_ack     = 1'b0;
        if (acc) begin
            if (nack) begin
                repeat (TPI) begin @(posedge clk); #1; end
            end else begin
                repeat (d - 1) begin @(posedge clk); #1; end
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        repeat (gap) begin
            @(posedge clk); #1;
            mem_ack = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: request launch, request hold, completion, stall accounting.
    initial begin
        logic        prev_req;
        int          stall_cnt;
        logic [64:0] cur;
        logic [40:0] r;
        prev_req  = 1'b0;
        stall_cnt = 0;
        cur       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("stall_in_reset", 32'(stall), 32'd0);
                stall_cnt = 0;
            end else if (stall) begin
                stall_cnt++;
            end
            if (mem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    fail_now("unexpected_request");
                end else begin
                    cur = req_q.pop_front();
                    chk("req_we", 32'(mem_we), 32'(cur[64]));
                    chk("req_addr", mem_addr, cur[63:32]);
                    chk("req_wdata", mem_wdata, cur[31:0]);
                end
            end else if (mem_req && prev_req) begin
                chk("hold_we", 32'(mem_we), 32'(cur[64]));
                chk("hold_addr", mem_addr, cur[63:32]);
                chk("hold_wdata", mem_wdata, cur[31:0]);
            end
            if (!rst && (dbg_state == 2'd2 || err === 1'b1)) begin
                if (res_q.size() == 0) begin
                    fail_now("unexpected_completion");
                end else begin
                    r = res_q.pop_front();
                    chk("rd_out", rd_out, r[40:9]);
                    chk("err", 32'(err), 32'(r[8]));
                    chk("stall_cycles", 32'(stall_cnt), 32'(r[7:0]));
                end
                stall_cnt = 0;
            end
            prev_req = mem_req;
        end
    end

    // Stimulus
    initial begin
        int k;
        int d;
        int gap;
        logic rd;
        logic wr;
        logic [31:0] a;
        rst         = 1'b1;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        addr_in     = 32'd0;
        wd_in       = 32'd0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'd0;
        rd_model    = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rd_out", rd_out, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Load with fastest ack, then a store acked in the 4th BUSY cycle.
        do_acc(1'b1, 1'b0, 32'h10, 32'h1234_5678, 1, 32'hCAFE_0001, 1);
        do_acc(1'b0, 1'b1, 32'h24, 32'h55AA_55AA, 4, 32'hFFFF_0000, 1);
        // Misaligned load, then load+store together.
        do_acc(1'b1, 1'b0, 32'h13, 32'h0, 1, 32'h0, 1);
        do_acc(1'b1, 1'b1, 32'h20, 32'h0, 1, 32'h0, 1);
        // Timeout, then ack on the timeout cycle.
        do_acc(1'b1, 1'b0, 32'h30, 32'h0, 0, 32'h0, 1);
        do_acc(1'b1, 1'b0, 32'h34, 32'h0, TPI, 32'h0BAD_F00D, 1);

        // Reset two cycles into a load; the late ack must be ignored.
        req_q.push_back({1'b0, 32'h40, 32'h7777_7777});
        @(posedge clk); #1;
        MemRead_in = 1'b1; addr_in = 32'h40; wd_in = 32'h7777_7777; mem_ack = 1'b0;
        @(posedge clk); #1;
        MemRead_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        rd_model = 32'd0;
        @(negedge clk);
        chk("rstbusy_mem_req", 32'(mem_req), 32'd0);
        chk("rstbusy_rd_out", rd_out, 32'd0);
        chk("rstbusy_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rstack_mem_req", 32'(mem_req), 32'd0);
        chk("rstack_rd_out", rd_out, 32'd0);
        chk("rstack_state", 32'(dbg_state), 32'd0);
        chk("rstack_err", 32'(err), 32'd0);

        // Back-to-back loads separated only by the DONE cycle.
        do_acc(1'b1, 1'b0, 32'h0, 32'h0, 1, 32'h1111_0000, 0);
        do_acc(1'b1, 1'b0, 32'h4, 32'h0, 2, 32'h2222_0004, 1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 9));
            a = $urandom();
            rd = 1'b0;
            wr = 1'b0;
            if (k < 4) begin
                rd = 1'b1; a[1:0] = 2'b00;
            end else if (k < 7) begin
                wr = 1'b1; a[1:0] = 2'b00;
            end else if (k == 7) begin
                rd = 1'b1; wr = 1'b1;
            end else begin
                rd = 1'($urandom_range(0, 1));
                wr = !rd;
                a[1:0] = 2'($urandom_range(1, 3));
            end
            d   = int'($urandom_range(0, 5));
            gap = int'($urandom_range(0, 2));
            do_acc(rd, wr, a, $urandom(), d, $urandom(), gap);
        end

        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
        mem_ack     = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("pending_requests", 32'(req_q.size()), 32'd0);
        chk("pending_completions", 32'(res_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_data_port.md
MEM_DATA_PORT -- requirements
Module: mem_data_port

Interface
REQ-001 Parameter TIMEOUT, default 8'd255: maximum cycles spent in BUSY waiting for mem_ack.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 MemRead_in  input  1  current MEM-stage instruction is a load.
REQ-005 MemWrite_in  input  1  current MEM-stage instruction is a store.
REQ-006 addr_in  input  32  byte address from ALU result.
REQ-007 wd_in  input  32  store data.
REQ-008 mem_req  output  1  request to data memory, registered.
REQ-009 mem_we  output  1  1 = write request, 0 = read request, registered.
REQ-010 mem_addr  output  32  registered request address.
REQ-011 mem_wdata  output  32  registered store data.
REQ-012 mem_ack  input  1  memory completion strobe, one cycle per request.
REQ-013 mem_rdata  input  32  load data, valid only when mem_ack=1.
REQ-014 rd_out  output  32  load data feeding the rd_in input of the MEM/WB register.
REQ-015 stall  output  1  combinational; 1 freezes PC, IF/ID, ID/EX, EX/MEM.
REQ-016 err  output  1  registered one-cycle pulse on a faulted access.

Function
REQ-017 States SHALL be IDLE, BUSY, DONE, in a registered 2-bit state.
REQ-018 Access request SHALL be defined as acc = MemRead_in XOR MemWrite_in, with addr_in[1:0]==2'b00.
REQ-019 In IDLE, when acc=1: latch addr_in, wd_in and MemWrite_in into mem_addr, mem_wdata and mem_we; set mem_req=1; clear timeout counter; go to BUSY.
REQ-020 In IDLE, when MemRead_in=MemWrite_in=1, or when either is 1 with addr_in[1:0]!=0: issue no request; pulse err=1 next cycle; leave rd_out unchanged; stall=0; remain IDLE.
REQ-021 stall SHALL be 1 in IDLE when acc=1, and 1 throughout BUSY; 0 in DONE and in every other case.
REQ-022 In BUSY, mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ack is sampled high.
REQ-023 In BUSY with mem_ack=1: drop mem_req; if mem_we=0, load rd_out with mem_rdata; go to DONE.
REQ-024 A store SHALL not modify rd_out.
REQ-025 In BUSY, an 8-bit counter SHALL increment each cycle without ack; when it reaches TIMEOUT with no ack: drop mem_req, set rd_out=32'd0 for a load, pulse err, go to DONE.
REQ-026 An ack in the same cycle as the timeout SHALL take priority (normal completion, no err).
REQ-027 DONE SHALL last exactly one cycle with stall=0 so the pipeline advances, then go to IDLE; acc is ignored in DONE.
REQ-028 Minimum access latency: request in cycle 0, mem_req high from cycle 1, ack in cycle 1 gives DONE in cycle 2, giving 2 stall cycles.
REQ-029 mem_ack sampled in IDLE or DONE SHALL be ignored.
REQ-030 rd_out SHALL hold its last value except as set by REQ-023, REQ-025 and reset.

Reset
REQ-031 With rst=1 at posedge, the next state SHALL be state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_out=0, err=0, counter=0.
REQ-032 Reset in BUSY SHALL abandon the access: mem_req=0 the next cycle, and a later ack for it is ignored.
REQ-033 stall SHALL be 0 during reset.

Verification
REQ-034 Load: MemRead_in=1, addr_in=32'h10, ack one cycle after mem_req with rdata=32'hCAFE_0001 -> mem_addr=32'h10, mem_we=0, stall high 2 cycles, rd_out=32'hCAFE_0001, err=0.
REQ-035 Store: MemWrite_in=1, addr_in=32'h24, wd_in=32'h55AA_55AA, ack delayed 4 cycles -> mem_we=1, mem_wdata=32'h55AA_55AA held stable 4 cycles, rd_out unchanged, stall high 5 cycles.
REQ-036 Misaligned: MemRead_in=1, addr_in=32'h13 -> mem_req stays 0, stall=0, err pulse 1 cycle; both MemRead_in and MemWrite_in high -> same result.
REQ-037 Timeout with TIMEOUT=4, load, never ack -> mem_req drops after 4 BUSY cycles, err=1 one cycle, rd_out=0; repeat with ack on the 4th cycle -> no err, rd_out=rdata.
REQ-038 Reset mid-BUSY: assert rst 2 cycles into a load, then ack 1 cycle later -> mem_req=0, rd_out=0, state IDLE, ack ignored.
REQ-039 Back-to-back loads at addr 0x0 then 0x4 -> two separate requests separated by one DONE cycle, rd_out updated in order.
